// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline latch enable/flush controller: load-use, taken-branch and data-miss handling.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_halt,
  input  logic             ex_dREN,
  input  logic             ex_WEN,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_branch_taken,
  output logic             pc_en,
  output logic             ifid_enable,
  output logic             ifid_flush,
  output logic             idex_enable,
  output logic             idex_flush,
  output logic             exmem_enable,
  output logic             exmem_flush,
  output logic             memwb_enable,
  output logic             memwb_flush,
  output logic             halted
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
`endif
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DWAIT = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t fsm_q, fsm_d;
  logic   ihit_seen_q, ihit_seen_d;

  logic dmiss;
  logic load_use;
  logic fetch_ok;
  logic branch_fire;

  assign dmiss    = (mem_dREN | mem_dWEN) & ~dhit;
  assign fetch_ok = ihit | ihit_seen_q;

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use = ex_dREN & ex_WEN & (ex_wsel != '0) &
                    ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));

  always_comb begin
    pc_en        = 1'b0;
    ifid_enable  = 1'b0;
    ifid_flush   = 1'b0;
    idex_enable  = 1'b0;
    idex_flush   = 1'b0;
    exmem_enable = 1'b0;
    exmem_flush  = 1'b0;
    memwb_enable = 1'b0;
    memwb_flush  = 1'b0;
    halted       = 1'b0;
    branch_fire  = 1'b0;
    fsm_d        = fsm_q;
    ihit_seen_d  = ihit_seen_q;

    if (!RST) begin
      if (fsm_q == S_HALT) begin
        halted = 1'b1;
      end else if (mem_halt) begin
        exmem_flush  = 1'b1;
        memwb_enable = 1'b1;
        fsm_d        = S_HALT;
      end else if (dmiss) begin
        // Freeze everything, but remember a fetch that completed during the miss.
        fsm_d       = S_DWAIT;
        ihit_seen_d = ihit_seen_q | ihit;
      end else if (ex_branch_taken) begin
        pc_en        = 1'b1;
        ifid_flush   = 1'b1;
        idex_flush   = 1'b1;
        exmem_enable = 1'b1;
        memwb_enable = 1'b1;
        branch_fire  = 1'b1;
        ihit_seen_d  = 1'b0;
        fsm_d        = S_RUN;
      end else if (load_use) begin
        idex_flush   = 1'b1;
        exmem_enable = 1'b1;
        memwb_enable = 1'b1;
        ihit_seen_d  = ihit_seen_q | ihit;
        fsm_d        = S_RUN;
      end else if (fetch_ok) begin
        pc_en        = 1'b1;
        ifid_enable  = 1'b1;
        idex_enable  = 1'b1;
        exmem_enable = 1'b1;
        memwb_enable = 1'b1;
        ihit_seen_d  = 1'b0;
        fsm_d        = S_RUN;
      end else begin
        // Fetch still outstanding: insert a bubble into IF/ID, let the rest drain.
        ifid_flush   = 1'b1;
        idex_enable  = 1'b1;
        exmem_enable = 1'b1;
        memwb_enable = 1'b1;
        fsm_d        = S_RUN;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fsm_q       <= S_RUN;
      ihit_seen_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      ihit_seen_q <= ihit_seen_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if ((fsm_q != S_HALT) && !pc_en) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
    if (branch_fire) begin
      flush_events_d = flush_events_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl (counters checked when HAZARD_PERF_CNT_EN is set).
module tb_pipeline_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  // Output vector order: pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl, memwb_en, memwb_fl, halted
  localparam logic [9:0] V_ZERO   = 10'b0_0_0_0_0_0_0_0_0_0;
  localparam logic [9:0] V_ALLEN  = 10'b1_1_0_1_0_1_0_1_0_0;
  localparam logic [9:0] V_LU     = 10'b0_0_0_0_1_1_0_1_0_0;
  localparam logic [9:0] V_BR     = 10'b1_0_1_0_1_1_0_1_0_0;
  localparam logic [9:0] V_PEND   = 10'b0_0_1_1_0_1_0_1_0_0;
  localparam logic [9:0] V_HLT1   = 10'b0_0_0_0_0_0_1_1_0_0;
  localparam logic [9:0] V_HALTED = 10'b0_0_0_0_0_0_0_0_0_1;

  logic             CLK = 1'b0;
  logic             RST;
  logic             ihit, dhit, mem_dREN, mem_dWEN, mem_halt;
  logic             ex_dREN, ex_WEN, id_uses_rt, ex_branch_taken;
  logic [REG_W-1:0] ex_wsel, id_rs, id_rt;
  logic             pc_en, ifid_enable, ifid_flush, idex_enable, idex_flush;
  logic             exmem_enable, exmem_flush, memwb_enable, memwb_flush, halted;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles, flush_events;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] exp_q[$];
  string      tag_q[$];
  logic [9:0] obs;

  assign obs = {pc_en, ifid_enable, ifid_flush, idex_enable, idex_flush,
                exmem_enable, exmem_flush, memwb_enable, memwb_flush, halted};

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_halt(mem_halt),
    .ex_dREN(ex_dREN), .ex_WEN(ex_WEN), .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_branch_taken(ex_branch_taken),
    .pc_en(pc_en), .ifid_enable(ifid_enable), .ifid_flush(ifid_flush),
    .idex_enable(idex_enable), .idex_flush(idex_flush),
    .exmem_enable(exmem_enable), .exmem_flush(exmem_flush),
    .memwb_enable(memwb_enable), .memwb_flush(memwb_flush), .halted(halted)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  task automatic clr_in();
    ihit = 0; dhit = 0; mem_dREN = 0; mem_dWEN = 0; mem_halt = 0;
    ex_dREN = 0; ex_WEN = 0; id_uses_rt = 0; ex_branch_taken = 0;
    ex_wsel = '0; id_rs = '0; id_rt = '0;
  endtask

  task automatic push_exp(input logic [9:0] e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic pop_cmp();
    logic [9:0] e;
    string      t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_tests++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", t, obs, e);
    end
  endtask

  // Inputs are already driven (#1 after a posedge); sample at the negedge, then advance one cycle.
  task automatic step(input logic [9:0] e, input string t);
    push_exp(e, t);
    @(negedge CLK);
    pop_cmp();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_now(input logic [9:0] e, input string t);
    push_exp(e, t);
    pop_cmp();
  endtask

  task automatic check_cnt(input logic [CNT_W-1:0] o, input logic [CNT_W-1:0] e, input string t);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", t, o, e);
    end
  endtask

  initial begin
    clr_in();
    RST  = 1'b1;
    ihit = 1'b1;
    @(posedge CLK); @(posedge CLK); #1;
    step(V_ZERO, "reset_hold");
    RST = 1'b0;

    clr_in();                               step(V_PEND,  "fetch_pending");
    ihit = 1;                               step(V_ALLEN, "fetch_ok");

    ex_dREN = 1; ex_WEN = 1; ex_wsel = 5; id_rs = 5; ihit = 1;
                                            step(V_LU,    "load_use_rs");
    clr_in();                               step(V_ALLEN, "load_use_release_seen");
                                            step(V_PEND,  "seen_cleared");

    ex_dREN = 1; ex_WEN = 1; ex_wsel = 7; id_rs = 3; id_rt = 7; id_uses_rt = 1; ihit = 1;
                                            step(V_LU,    "load_use_rt");
    id_uses_rt = 0;                         step(V_ALLEN, "rt_unused_no_stall");
    ex_WEN = 0; id_uses_rt = 1;             step(V_ALLEN, "no_wen_no_stall");

    clr_in(); ex_dREN = 1; ex_WEN = 1; ex_wsel = 0; id_rs = 0; ihit = 1;
                                            step(V_ALLEN, "reg0_no_stall");

    clr_in(); mem_dREN = 1; ihit = 1;       step(V_ZERO,  "dmiss_1");
    ihit = 0;                               step(V_ZERO,  "dmiss_2");
                                            step(V_ZERO,  "dmiss_3");
    dhit = 1;                               step(V_ALLEN, "dhit_release_seen");
    clr_in();                               step(V_PEND,  "dmiss_seen_cleared");

    mem_dWEN = 1;                           step(V_ZERO,  "store_miss");
    dhit = 1; ihit = 1;                     step(V_ALLEN, "store_hit_release");

    clr_in(); ex_branch_taken = 1; ex_dREN = 1; ex_WEN = 1; ex_wsel = 5; id_rs = 5;
                                            step(V_BR,    "branch_beats_load_use");
    mem_dREN = 1;                           step(V_ZERO,  "dmiss_beats_branch");
    dhit = 1;                               step(V_BR,    "branch_after_dhit");

    clr_in(); mem_dREN = 1; ihit = 1;       step(V_ZERO,  "dmiss_before_reset");
    mem_dREN = 0; #1;
    check_now(V_ALLEN, "pre_reset_seen");
    #2; RST = 1'b1; #1;
    check_now(V_ZERO, "async_reset");
    @(posedge CLK); #1;
    RST = 1'b0; clr_in();                   step(V_PEND,  "post_reset_seen_clear");

    ihit = 1; mem_halt = 1; mem_dREN = 1; ex_branch_taken = 1;
                                            step(V_HLT1,  "halt_in_mem");
    clr_in(); ihit = 1; dhit = 1;           step(V_HALTED, "halted_1");
    ex_branch_taken = 1; mem_dREN = 1;      step(V_HALTED, "halted_2");
    clr_in(); ihit = 1;                     step(V_HALTED, "halted_3");

    RST = 1'b1; #1;
    check_now(V_ZERO, "reset_in_halt");
    @(posedge CLK); #1;
    RST = 1'b0;                             step(V_ALLEN, "exit_halt_by_reset");

`ifdef HAZARD_PERF_CNT_EN
    RST = 1'b1; clr_in();
    @(posedge CLK); #1;
    check_cnt(stall_cycles, '0, "stall_cnt_reset");
    check_cnt(flush_events, '0, "flush_cnt_reset");
    mem_dREN = 1;
    @(negedge CLK); RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    dhit = 1; ex_branch_taken = 1;
    @(posedge CLK); #1;
    check_cnt(stall_cycles, 32'd3, "stall_cycles");
    check_cnt(flush_events, 32'd1, "flush_events");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
